bcd_serial_adder: RTL

Digit-serial BCD add/subtract controller. It accepts two DIGITS-digit packed-BCD operands over a valid/ready handshake and sequences a single one-digit BCD adder across the digits, least-significant digit first, one digit per clock. It presents the result, carry/no-borrow and a digit-error flag on a second valid/ready handshake. It replaces a ripple chain of per-digit adders wherever area matters more than latency.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_add.sv | 37 +++
 rtl/bcd_serial_adder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder: digit geometry,
// controller state encoding and the 9's complement helper.
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wraps modulo 16 so invalid codes still give a deterministic operand.
  function automatic logic [BCD_DIGIT_W-1:0] nines_comp(input logic [BCD_DIGIT_W-1:0] d);
    nines_comp = BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder/subtractor with decimal correction and
// invalid-digit detection; purely combinational.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_a,
  input  logic [BCD_DIGIT_W-1:0] i_b,
  input  logic                   i_cin,
  input  logic                   i_sub,
  output logic [BCD_DIGIT_W-1:0] o_digit,
  output logic                   o_cout,
  output logic                   o_bad
);

  logic [BCD_DIGIT_W-1:0] w_bd;
  logic [BCD_DIGIT_W:0]   w_raw;
  logic [BCD_DIGIT_W-1:0] w_adj;

  // Digit sum, +6 correction above nine, and operand validity check.
  always_comb begin
    w_bd    = i_sub ? nines_comp(i_b) : i_b;
    w_raw   = {1'b0, i_a} + {1'b0, w_bd} + {4'd0, i_cin};
    w_adj   = w_raw[BCD_DIGIT_W-1:0] + 4'd6;
    o_digit = w_raw[BCD_DIGIT_W-1:0];
    o_cout  = 1'b0;
    if (w_raw > {1'b0, BCD_MAX}) begin
      o_digit = w_adj;
      o_cout  = 1'b1;
    end else begin
      o_digit = w_raw[BCD_DIGIT_W-1:0];
      o_cout  = 1'b0;
    end
    // Validity is judged on the original B digit, not its complement.
    o_bad = (i_a > BCD_MAX) | (i_b > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD add/subtract controller: one shared digit adder
// stepped LSD-first across DIGITS digits between two valid/ready handshakes.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
  input  logic                          cin,
  input  logic                          sub,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
  output logic                          cout,
  output logic                          err
);

  localparam int               W     = BCD_DIGIT_W * DIGITS;
  localparam int               CNT_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIGITS - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [W-1:0]           r_a_sr;
  logic [W-1:0]           r_b_sr;
  logic [W-1:0]           r_sum;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_carry;
  logic                   r_sub;
  logic                   r_cout;
  logic                   r_err;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   w_accept;
  logic                   w_last;
  logic [BCD_DIGIT_W-1:0] w_digit;
  logic                   w_dcout;
  logic                   w_bad;

  assign w_accept  = in_valid & r_in_ready;
  assign w_last    = (r_cnt == LAST);
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign err       = r_err;

  bcd_digit_add u_digit (
    .i_a     (r_a_sr[BCD_DIGIT_W-1:0]),
    .i_b     (r_b_sr[BCD_DIGIT_W-1:0]),
    .i_cin   (r_carry),
    .i_sub   (r_sub),
    .o_digit (w_digit),
    .o_cout  (w_dcout),
    .o_bad   (w_bad)
  );

  // Next-state decode for the IDLE/RUN/DONE controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = RUN;
        else          w_state_nxt = IDLE;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
        else        w_state_nxt = RUN;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
        else           w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus handshake flags registered from the next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Operand capture on accept, then one digit step per RUN cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a_sr  <= {W{1'b0}};
      r_b_sr  <= {W{1'b0}};
      r_sum   <= {W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= sub ? 1'b1 : cin;
            r_sub   <= sub;
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_cnt   <= r_cnt;
          end
        end
        RUN: begin
          r_a_sr  <= {{BCD_DIGIT_W{1'b0}}, r_a_sr[W-1:BCD_DIGIT_W]};
          r_b_sr  <= {{BCD_DIGIT_W{1'b0}}, r_b_sr[W-1:BCD_DIGIT_W]};
          r_sum   <= {w_digit, r_sum[W-1:BCD_DIGIT_W]};
          r_carry <= w_dcout;
          r_cout  <= w_dcout;
          // The first digit restarts the error flag so it never leaks between operations.
          r_err   <= ((r_cnt == {CNT_W{1'b0}}) ? 1'b0 : r_err) | w_bad;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule
